// File: rtl/lsu_mem_ctrl.sv
// Load/store controller: effective address, lane steering and AXI4-Lite AR/R and AW/W/B sequencing.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned requests complete with err_o=1 and no bus traffic.
module lsu_mem_ctrl #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [3:0]            lsu_op_i,
  input  logic [DATA_W-1:0]     imm_i,
  input  logic [DATA_W-1:0]     rdata1_i,
  input  logic [DATA_W-1:0]     rdata2_i,
  output logic [ADDR_W-1:0]     araddr_o,
  output logic                  arvalid_o,
  input  logic                  arready_i,
  input  logic [DATA_W-1:0]     rdata_i,
  input  logic [1:0]            rresp_i,
  input  logic                  rvalid_i,
  output logic                  rready_o,
  output logic [ADDR_W-1:0]     awaddr_o,
  output logic                  awvalid_o,
  input  logic                  awready_i,
  output logic [DATA_W-1:0]     wdata_o,
  output logic [DATA_W/8-1:0]   wstrb_o,
  output logic                  wvalid_o,
  input  logic                  wready_i,
  input  logic [1:0]            bresp_i,
  input  logic                  bvalid_i,
  output logic                  bready_o,
  output logic                  done_o,
  output logic [DATA_W-1:0]     ldata_o,
  output logic                  err_o
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned OFF_W  = $clog2(STRB_W);

  typedef enum logic [2:0] {IDLE, RADDR, RDATA, WREQ, WRESP, DONE} state_e;

  state_e               state_q;
  logic [OFF_W-1:0]     off_q;
  logic [3:0]           op_q;
  logic [ADDR_W-1:0]    araddr_q, awaddr_q;
  logic                 arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q, done_q, err_q;
  logic [DATA_W-1:0]    wdata_q, ldata_q;
  logic [STRB_W-1:0]    wstrb_q;

  logic [DATA_W-1:0]    sum_d, wdata_d, shifted_d, ldata_d;
  logic [ADDR_W-1:0]    ea_d, aligned_d;
  logic [OFF_W-1:0]     off_d;
  logic [STRB_W-1:0]    strb_d;
  logic [31:0]          off_n, bytes_n, nbits_n;
  logic                 illegal_d, trap_d, sgn_d;

  always_comb begin
    sum_d     = rdata1_i + imm_i;
    ea_d      = ADDR_W'(sum_d);
    aligned_d = ea_d;
    aligned_d[OFF_W-1:0] = '0;
    off_d     = ea_d[OFF_W-1:0];
    off_n     = 32'(off_d);
    bytes_n   = 32'd1 << lsu_op_i[1:0];
    // Lanes past the top of the bus fall outside the loop and are dropped.
    strb_d = '0;
    for (int unsigned i = 0; i < STRB_W; i++) begin
      strb_d[i] = (i >= off_n) && (i < off_n + bytes_n);
    end
    wdata_d   = rdata2_i << {off_d, 3'b000};
    illegal_d = (lsu_op_i[1:0] == 2'd3) && (DATA_W != 64);
`ifdef LSU_MISALIGN_TRAP_EN
    trap_d = illegal_d || ((off_n & (bytes_n - 32'd1)) != 32'd0) || (off_n + bytes_n > STRB_W);
`else
    trap_d = illegal_d;
`endif
  end

  always_comb begin
    shifted_d = rdata_i >> {off_q, 3'b000};
    nbits_n   = 32'd8 << op_q[1:0];
    sgn_d     = 1'b0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      if (i == nbits_n - 32'd1) sgn_d = shifted_d[i];
    end
    ldata_d = '0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      ldata_d[i] = (i < nbits_n) ? shifted_d[i] : (sgn_d & ~op_q[2]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      off_q     <= '0;
      op_q      <= '0;
      araddr_q  <= '0;
      awaddr_q  <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      ldata_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (req_valid_i) begin
          off_q <= off_d;
          op_q  <= lsu_op_i;
          if (trap_d) begin
            err_q   <= 1'b1;
            ldata_q <= '0;
            state_q <= DONE;
          end else if (lsu_op_i[3]) begin
            awaddr_q  <= aligned_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= strb_d;
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            state_q   <= WREQ;
          end else begin
            araddr_q  <= aligned_d;
            arvalid_q <= 1'b1;
            state_q   <= RADDR;
          end
        end
        RADDR: if (arready_i) begin
          arvalid_q <= 1'b0;
          rready_q  <= 1'b1;
          state_q   <= RDATA;
        end
        RDATA: if (rvalid_i) begin
          rready_q <= 1'b0;
          ldata_q  <= ldata_d;
          err_q    <= |rresp_i;
          done_q   <= 1'b1;
          state_q  <= DONE;
        end
        WREQ: begin
          if (awready_i) awvalid_q <= 1'b0;
          if (wready_i)  wvalid_q  <= 1'b0;
          if ((!awvalid_q || awready_i) && (!wvalid_q || wready_i)) begin
            bready_q <= 1'b1;
            state_q  <= WRESP;
          end
        end
        WRESP: if (bvalid_i) begin
          bready_q <= 1'b0;
          ldata_q  <= '0;
          err_q    <= |bresp_i;
          done_q   <= 1'b1;
          state_q  <= DONE;
        end
        // Trapped requests enter DONE with done_q low and pulse one cycle later.
        DONE: begin
          if (done_q) state_q <= IDLE;
          else        done_q  <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready_o = (state_q == IDLE);
  assign araddr_o    = araddr_q;
  assign arvalid_o   = arvalid_q;
  assign rready_o    = rready_q;
  assign awaddr_o    = awaddr_q;
  assign awvalid_o   = awvalid_q;
  assign wdata_o     = wdata_q;
  assign wstrb_o     = wstrb_q;
  assign wvalid_o    = wvalid_q;
  assign bready_o    = bready_q;
  assign done_o      = done_q;
  assign ldata_o     = ldata_q;
  assign err_o       = err_q;

endmodule
